latch_feed_debouncer: RTL and testbench



---
 rtl/latch_feed_pkg.sv | 17 +
 rtl/latch_feed_debouncer_sync_2ff.sv | 26 ++
 rtl/latch_feed_debouncer.sv | 100 ++++++++++
 tb/tb_latch_feed_debouncer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/latch_feed_pkg.sv
// Shared definitions for the latch feed debouncer: FSM state encoding
// and the default qualification window.
package latch_feed_pkg;

  // Two-state qualifier: idle on a settled level, or timing a candidate change.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } feedState_e;

  // Default number of consecutive synchronised cycles a new level must hold.
  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Default width of the stability counter.
  localparam int DEFAULT_CNT_W = 16;

endpackage : latch_feed_pkg

// File: rtl/latch_feed_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. Both stages
// clear synchronously so the debouncer starts from a known low level.
module sync_2ff (
  input  logic clock_i,
  input  logic reset_i,
  input  logic asyncIn_i,
  output logic syncOut_o
);

  logic stage1_q;
  logic stage2_q;

  // Shift the raw level through two flops to let metastability settle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= asyncIn_i;
      stage2_q <= stage1_q;
    end
  end

  assign syncOut_o = stage2_q;

endmodule : sync_2ff

// File: rtl/latch_feed_debouncer.sv
// Debounced feeder for a level-sensitive D/En latch. The raw pin is
// synchronised, a candidate change is timed for STABLE_CYCLES cycles, and
// only a change that survives the whole window updates D together with a
// single-cycle En strobe. Every output comes straight from a flop.
module latch_feed_debouncer
  import latch_feed_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Din_raw,
  output logic D,
  output logic En,
  output logic Busy
);

  // Reject an unusable window at elaboration: fewer than two cycles cannot
  // filter anything, and the terminal count must fit in the counter.
  if ((STABLE_CYCLES < 2) ||
      (longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - longint'(1)))) begin : gBadStableCycles
    $error("latch_feed_debouncer: STABLE_CYCLES must lie in 2..2**CNT_W-1");
  end

  // Count value on which a still-mismatching candidate is accepted.
  localparam logic [CNT_W-1:0] CntTerminal = CNT_W'(STABLE_CYCLES - 1);

  logic syncLevel;

  feedState_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             data_q,  data_d;
  logic             en_q,    en_d;
  logic             busy_q,  busy_d;

  sync_2ff uSync (
    .clock_i   (Clk),
    .reset_i   (Rst),
    .asyncIn_i (Din_raw),
    .syncOut_o (syncLevel)
  );

  // Next-state logic: start timing on a mismatch, abandon on a return to
  // the current level, accept when the mismatch reaches the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    en_d    = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (syncLevel != data_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHECK: begin
        if (syncLevel == data_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CntTerminal) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          data_d  = syncLevel;
          en_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase

    busy_d = (state_d == ST_CHECK);
  end

  // State, counter and output registers; reset wins over any qualification.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign D    = data_q;
  assign En   = en_q;
  assign Busy = busy_q;

endmodule : latch_feed_debouncer

// File: tb/tb_latch_feed_debouncer.sv
// Self-checking bench for latch_feed_debouncer with the default window of
// four cycles: a per-cycle vector table for reset, clean rise and glitch,
// then hand-written sequences for bouncing, reset mid-check and rise/fall.
module tb_latch_feed_debouncer;

  logic Clk;
  logic Rst;
  logic Din_raw;
  logic D;
  logic En;
  logic Busy;

  int checks;
  int errors;
  int cycNum;

  typedef struct {
    logic rst;
    logic din;
    logic expD;
    logic expEn;
    logic expBusy;
  } vector_t;

  vector_t vecs[$];

  latch_feed_debouncer #(
    .STABLE_CYCLES (4),
    .CNT_W         (16)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Din_raw (Din_raw),
    .D       (D),
    .En      (En),
    .Busy    (Busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Drive one cycle of inputs, let the rising edge take them, sample after it.
  task automatic applyStimulus(input logic rst, input logic din);
    Rst     = rst;
    Din_raw = din;
    @(posedge Clk);
    #1;
    cycNum++;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycNum);
    end
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int enAt;
    int firstEn;
    int secondEn;

    checks  = 0;
    errors  = 0;
    cycNum  = 0;
    Rst     = 1'b1;
    Din_raw = 1'b0;

    // Reset held three cycles with the pin high, then a clean rise.
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    // Reset back to low, then a three-sample glitch that must be rejected.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("[TB] vector table: %0d cycles", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].din);
      checkOutput($sformatf("vec%0d_D", i),    int'(D),    int'(vecs[i].expD));
      checkOutput($sformatf("vec%0d_En", i),   int'(En),   int'(vecs[i].expEn));
      checkOutput($sformatf("vec%0d_Busy", i), int'(Busy), int'(vecs[i].expBusy));
    end

    // Bounce train: two-cycle toggles never qualify, final hold does.
    $display("[TB] bounce train");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, ((i / 2) % 2) == 0);
      if (En) pulses++;
    end
    checkOutput("bounce_d_held_low", int'(D), 0);
    enAt = -1;
    for (int j = 0; j < 12; j++) begin
      applyStimulus(1'b0, 1'b1);
      if (En) begin
        pulses++;
        if (enAt < 0) enAt = j;
      end
    end
    checkOutput("bounce_en_count", pulses, 1);
    checkOutput("bounce_en_latency", enAt, 5);
    checkOutput("bounce_final_d", int'(D), 1);

    // Reset while the counter sits at two aborts the change; it restarts after.
    $display("[TB] reset mid-check");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("midcheck_busy_before", int'(Busy), 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midcheck_busy_after_rst", int'(Busy), 0);
    checkOutput("midcheck_d_after_rst",    int'(D),    0);
    checkOutput("midcheck_en_after_rst",   int'(En),   0);
    pulses = 0;
    enAt   = -1;
    for (int j = 0; j < 12; j++) begin
      applyStimulus(1'b0, 1'b1);
      if (En) begin
        pulses++;
        if (enAt < 0) enAt = j;
      end
    end
    checkOutput("restart_en_count",   pulses, 1);
    checkOutput("restart_en_latency", enAt,   5);
    checkOutput("restart_d",          int'(D), 1);

    // Rise then fall: two strobes, the second a fixed distance after the first.
    $display("[TB] rise then fall");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pulses   = 0;
    firstEn  = -1;
    secondEn = -1;
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 1'b1);
      if (En) begin
        pulses++;
        if (firstEn < 0) firstEn = cycNum;
      end
    end
    checkOutput("rise_d", int'(D), 1);
    for (int j = 0; j < 12; j++) begin
      applyStimulus(1'b0, 1'b0);
      if (En) begin
        pulses++;
        if (secondEn < 0) secondEn = cycNum;
      end
    end
    checkOutput("risefall_en_count", pulses, 2);
    checkOutput("risefall_first_en_seen", int'(firstEn >= 0), 1);
    checkOutput("risefall_en_spacing", secondEn - firstEn, 8);
    checkOutput("fall_d", int'(D), 0);
    checkOutput("fall_busy_idle", int'(Busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_latch_feed_debouncer
